// File: rtl/div_seq.sv
// =============================================================================
// div_seq : sequential signed restoring divider, one quotient bit per clock
// Revision: 1.0
// =============================================================================
`default_nettype none

module div_seq #(
    parameter int BITS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] hi,
    output logic [BITS-1:0] low,
    output logic            busy,
    output logic            done,
    output logic            div_zero
);

    localparam int CW = $clog2(BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [BITS-1:0] dvs_q, dvs_d;
    logic [BITS-1:0] quo_q, quo_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] hi_q, hi_d;
    logic [BITS-1:0] low_q, low_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;

    // The stored remainder is always below |b|, so only the shifted value
    // needs the extra top bit.
    logic [BITS:0]   rem_sh;
    logic            rem_ge;

    assign rem_sh = {rem_q, quo_q[BITS-1]};
    assign rem_ge = (rem_sh >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        low_d   = low_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // busy while idle marks a divide-by-zero accepted last edge
                if (busy_q) begin
                    done_d = 1'b1;
                    dz_d   = 1'b1;
                    busy_d = 1'b0;
                end else if (start) begin
                    qneg_d = a[BITS-1] ^ b[BITS-1];
                    rneg_d = a[BITS-1];
                    dvs_d  = b[BITS-1] ? -b : b;
                    quo_d  = a[BITS-1] ? -a : a;
                    rem_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (b != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_ge ? rem_sh[BITS-1:0] - dvs_q : rem_sh[BITS-1:0];
                quo_d = {quo_q[BITS-2:0], rem_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(BITS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                low_d   = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            low_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            low_q   <= low_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign low      = low_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// =============================================================================
// tb_div_seq : directed self-checking bench for div_seq
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_div_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] low;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    div_seq #(.BITS(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .low      (low),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Launch a division and wait (bounded) for done; samples #1 after edges.
    task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input bit now,
                          output int lat, output logic [31:0] lo, output logic [31:0] rh,
                          output logic bz, output logic dz);
        if (!now) @(negedge clock);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        lo = low;
        rh = hi;
        bz = busy;
        dz = div_zero;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        total++;
        if ({hi, low, busy, done, div_zero} !== 67'd0) begin
            bad++;
            $display("FAIL reset: hi=%h low=%h busy=%b done=%b dz=%b, want all zero",
                     hi, low, busy, done, div_zero);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_vectors();
        logic [31:0] va [10] = '{32'd7, 32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9,
                                 32'h80000000, 32'd0, 32'd5, 32'd50, 32'd9};
        logic [31:0] vb [10] = '{32'd2, 32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                 32'hFFFFFFFF, 32'd5, 32'd9, 32'd3, 32'd4};
        logic [31:0] el [10] = '{32'd3, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3,
                                 32'h80000000, 32'd0, 32'd0, 32'd16, 32'd2};
        logic [31:0] eh [10] = '{32'd1, 32'd2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
                                 32'd0, 32'd0, 32'd5, 32'd2, 32'd1};
        int lat;
        logic [31:0] lo, rh;
        logic bz, dz;
        for (int i = 0; i < 10; i++) begin
            do_div(va[i], vb[i], 1'b0, lat, lo, rh, bz, dz);
            total++;
            if (lat !== 33 || lo !== el[i] || rh !== eh[i] || bz !== 1'b0 || dz !== 1'b0) begin
                bad++;
                $display("FAIL div[%0d] %h/%h: lat=%0d low=%h hi=%h busy=%b dz=%b, want lat=33 low=%h hi=%h busy=0 dz=0",
                         i, va[i], vb[i], lat, lo, rh, bz, dz, el[i], eh[i]);
            end
        end
        @(posedge clock);
        #1;
        total++;
        if (done !== 1'b0 || low !== 32'd2 || hi !== 32'd1) begin
            bad++;
            $display("FAIL done_pulse: done=%b low=%h hi=%h, want done=0 low=2 hi=1", done, low, hi);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [31:0] lo, rh;
        logic bz, dz;
        do_div(32'd123, 32'd0, 1'b0, lat, lo, rh, bz, dz);
        total++;
        if (lat !== 1 || dz !== 1'b1 || bz !== 1'b0 || lo !== 32'd2 || rh !== 32'd1) begin
            bad++;
            $display("FAIL div_zero: lat=%0d dz=%b busy=%b low=%h hi=%h, want lat=1 dz=1 busy=0 low=2 hi=1",
                     lat, dz, bz, lo, rh);
        end
        @(posedge clock);
        #1;
        total++;
        if (done !== 1'b0 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL div_zero_pulse: done=%b dz=%b, want 0 0", done, div_zero);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clock);
        a = 32'd50;
        b = 32'd3;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 10) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_mid: busy=%b, want 1", busy);
                end
                a = 32'd1;
                b = 32'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        start = 1'b0;
        total++;
        if (lat !== 33 || low !== 32'd16 || hi !== 32'd2) begin
            bad++;
            $display("FAIL busy_ignore: lat=%0d low=%h hi=%h, want lat=33 low=16 hi=2", lat, low, hi);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] lo, rh;
        logic bz, dz;
        do_div(32'd100, 32'd7, 1'b0, lat, lo, rh, bz, dz);
        do_div(32'd9, 32'd3, 1'b1, lat, lo, rh, bz, dz);
        total++;
        if (lat !== 33 || lo !== 32'd3 || rh !== 32'd0) begin
            bad++;
            $display("FAIL back_to_back: lat=%0d low=%h hi=%h, want lat=33 low=3 hi=0", lat, lo, rh);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [31:0] lo, rh;
        logic bz, dz;
        do_div(32'd100, 32'd7, 1'b0, lat, lo, rh, bz, dz);
        @(negedge clock);
        a = 32'd1000;
        b = 32'd7;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || low !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h low=%h, want all zero", busy, done, hi, low);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_abort: done pulses=%0d, want 0", seen);
        end
        do_div(32'd1000, 32'd7, 1'b0, lat, lo, rh, bz, dz);
        total++;
        if (lat !== 33 || lo !== 32'd142 || rh !== 32'd6) begin
            bad++;
            $display("FAIL after_reset: lat=%0d low=%h hi=%h, want lat=33 low=142 hi=6", lat, lo, rh);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
